// File: rtl/mult8_pkg.sv
// mult8_pkg: shared types and constants for the 8x8 signed shift-add multiplier.
package mult8_pkg;

  localparam int WIDTH = 8;

  // Count value of the eighth and final add-shift step (the subtract step).
  localparam logic [2:0] LAST_STEP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COMPUTE,
    DONE
  } state_t;

endpackage

// File: rtl/mult8_shift_add_add_sub9.sv
// add_sub9: 9-bit sign-extending ripple adder/subtractor.
// Both 8-bit operands are sign-extended to 9 bits. With sub=1 the B operand
// is inverted and the carry-in forced to 1, giving A - B.
// X is the ninth (sign) bit of the result.
module add_sub9
  import mult8_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             X
);

  logic [WIDTH:0] a9;
  logic [WIDTH:0] b9;
  logic [WIDTH:0] s9;
  logic           carry;

  // Ripple-carry sum over the sign-extended operands.
  always_comb begin
    a9    = {A[WIDTH-1], A};
    b9    = {B[WIDTH-1], B} ^ {(WIDTH+1){sub}};
    s9    = '0;
    carry = sub;
    for (int i = 0; i <= WIDTH; i++) begin
      s9[i] = a9[i] ^ b9[i] ^ carry;
      carry = (a9[i] & b9[i]) | (carry & (a9[i] ^ b9[i]));
    end
  end

  assign S = s9[WIDTH-1:0];
  assign X = s9[WIDTH];

endmodule

// File: rtl/mult8_shift_add.sv
// mult8_shift_add: sequential 8x8 signed shift-add multiplier.
// B holds the multiplier, M the multiplicand; after eight add-shift steps the
// 16-bit signed product sits in {A,B} and X mirrors A[7].
// Optional macro MULT_INPUT_SYNC_EN: pass Run, ClearA_LoadB and S through
// two-flop synchronizers (adds two cycles of start latency).
//
// Handshake: Run is a level request; a 0->1 edge seen in IDLE starts one
// multiply. Busy is high in CLEAR/COMPUTE, Done is high in DONE and stays
// high until Run is released, so a held Run never restarts the multiply.
module mult8_shift_add
  import mult8_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done,
  output state_t           dbg_state
);

  logic             run_s;
  logic             clr_s;
  logic [WIDTH-1:0] s_s;

`ifdef MULT_INPUT_SYNC_EN
  logic [1:0]       run_sync;
  logic [1:0]       clr_sync;
  logic [WIDTH-1:0] s_sync1;
  logic [WIDTH-1:0] s_sync2;

  // Two-flop synchronizers for the switch/button inputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      run_sync <= '0;
      clr_sync <= '0;
      s_sync1  <= '0;
      s_sync2  <= '0;
    end else begin
      run_sync <= {run_sync[0], Run};
      clr_sync <= {clr_sync[0], ClearA_LoadB};
      s_sync1  <= S;
      s_sync2  <= s_sync1;
    end
  end

  assign run_s = run_sync[1];
  assign clr_s = clr_sync[1];
  assign s_s   = s_sync2;
`else
  assign run_s = Run;
  assign clr_s = ClearA_LoadB;
  assign s_s   = S;
`endif

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [2:0]       cnt;
  logic             run_q;
  logic [WIDTH-1:0] sum_lo;
  logic             sum_hi;

  // The final step subtracts M: the multiplier's MSB carries negative weight.
  add_sub9 u_add_sub9 (
    .A   (Aval),
    .B   (m_reg),
    .sub (cnt == LAST_STEP),
    .S   (sum_lo),
    .X   (sum_hi)
  );

  // Control FSM together with the X/A/B/M datapath registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      Aval  <= '0;
      Bval  <= '0;
      X     <= 1'b0;
      m_reg <= '0;
      cnt   <= '0;
      run_q <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      run_q <= run_s;
      case (state)
        IDLE: begin
          if (run_s && !run_q) begin
            m_reg <= s_s;
            Busy  <= 1'b1;
            state <= CLEAR;
          end else if (clr_s) begin
            Aval <= '0;
            X    <= 1'b0;
            Bval <= s_s;
          end
        end
        CLEAR: begin
          Aval  <= '0;
          X     <= 1'b0;
          cnt   <= '0;
          state <= COMPUTE;
        end
        COMPUTE: begin
          if (Bval[0]) begin
            X    <= sum_hi;
            Aval <= {sum_hi, sum_lo[WIDTH-1:1]};
            Bval <= {sum_lo[0], Bval[WIDTH-1:1]};
          end else begin
            Aval <= {X, Aval[WIDTH-1:1]};
            Bval <= {Aval[0], Bval[WIDTH-1:1]};
          end
          cnt <= cnt + 3'd1;
          if (cnt == LAST_STEP) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!run_s) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mult8_shift_add.sv
// tb_mult8_shift_add: table-driven and scoreboarded bench for mult8_shift_add.
module tb_mult8_shift_add;
  import mult8_pkg::*;

`ifdef MULT_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int START_LAT = 10 + SYNC_LAT;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Busy;
  logic       Done;
  state_t     dbg_state;

  mult8_shift_add dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Busy         (Busy),
    .Done         (Done),
    .dbg_state    (dbg_state)
  );

  // Clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  cur_b;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  m;
    logic [15:0] prod;
    logic        x;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] b, input logic [7:0] m);
    logic signed [15:0] p;
    p = 16'($signed(b)) * 16'($signed(m));
    return {p[15], p};
  endfunction

  // Driver: load B from S through ClearA_LoadB while idle.
  task automatic load_b(input logic [7:0] b);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    S            = b;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    repeat (3) @(negedge Clk);
    check("load_b", Bval, b);
    check("load_a", {X, Aval}, 9'h0);
    cur_b = b;
  endtask

  // Driver + monitor for one multiply; exp is {X, product}.
  task automatic run_mult(input logic [7:0] m, input logic [16:0] exp,
                          input bit clr_at_start, input bit clr_mid, input int hold_cycles);
    int          lat;
    int          busy_cnt;
    bit          got;
    logic [16:0] e;
    exp_q.push_back(exp);
    @(negedge Clk);
    Run = 1'b1;
    S   = m;
    if (clr_at_start) ClearA_LoadB = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge Clk);
      #1;
      if (Busy) busy_cnt++;
      if (Done) begin
        got = 1'b1;
        lat = c;
      end
      if (c == 1) ClearA_LoadB = 1'b0;
      if (clr_mid && c == 4) begin
        ClearA_LoadB = 1'b1;
        S            = 8'h55;
      end
      if (clr_mid && c == 6) ClearA_LoadB = 1'b0;
    end
    check("done_seen", 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      check("latency", lat, START_LAT);
      check("busy_cycles", busy_cnt, 9);
      check("product", {X, Aval, Bval}, e);
    end
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge Clk);
      #1;
      check("done_hold", Done, 1'b1);
      check("busy_hold", Busy, 1'b0);
    end
    @(negedge Clk);
    Run = 1'b0;
    repeat (4) @(negedge Clk);
    check("done_clear", Done, 1'b0);
    check("state_idle", dbg_state, IDLE);
    cur_b = e[7:0];
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rm;

    vecs[0] = '{b: 8'hFD, m: 8'h07, prod: 16'hFFEB, x: 1'b1};
    vecs[1] = '{b: 8'h80, m: 8'h80, prod: 16'h4000, x: 1'b0};
    vecs[2] = '{b: 8'h7F, m: 8'h7F, prod: 16'h3F01, x: 1'b0};
    vecs[3] = '{b: 8'hFF, m: 8'hFF, prod: 16'h0001, x: 1'b0};
    vecs[4] = '{b: 8'h00, m: 8'h55, prod: 16'h0000, x: 1'b0};
    vecs[5] = '{b: 8'h01, m: 8'h80, prod: 16'hFF80, x: 1'b1};
    vecs[6] = '{b: 8'h80, m: 8'h01, prod: 16'hFF80, x: 1'b1};
    vecs[7] = '{b: 8'h7F, m: 8'h80, prod: 16'hC080, x: 1'b1};

    // Reset with random inputs
    Reset_n      = 1'b0;
    Run          = 1'($urandom_range(0, 1));
    ClearA_LoadB = 1'($urandom_range(0, 1));
    S            = 8'($urandom_range(0, 255));
    cur_b        = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_a", Aval, 8'h00);
    check("rst_b", Bval, 8'h00);
    check("rst_x", X, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_state", dbg_state, IDLE);
    @(negedge Clk);
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = 8'h00;
    Reset_n      = 1'b1;
    repeat (3) @(negedge Clk);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      load_b(vecs[i].b);
      run_mult(vecs[i].m, {vecs[i].x, vecs[i].prod}, 1'b0, 1'b0, 0);
    end

    // Random operands against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255));
      load_b(rb);
      run_mult(rm, model(rb, rm), 1'b0, 1'b0, 0);
    end

    // Run rise and ClearA_LoadB together: Run wins, B keeps 3
    load_b(8'h03);
    run_mult(8'hF9, {1'b1, 16'hFFEB}, 1'b1, 1'b0, 0);

    // ClearA_LoadB with S=0x55 during COMPUTE is ignored
    load_b(8'h0B);
    run_mult(8'h05, {1'b0, 16'h0037}, 1'b0, 1'b1, 0);

    // Run held past DONE, then re-raised: B = previous low byte, A cleared
    load_b(8'h80);
    run_mult(8'h7F, {1'b1, 16'hC080}, 1'b0, 1'b0, 5);
    run_mult(8'h02, {1'b1, 16'hFF00}, 1'b0, 1'b0, 0);

    // Reset sampled at E5 of a multiply
    load_b(8'hFD);
    @(negedge Clk);
    Run = 1'b1;
    S   = 8'h07;
    repeat (5 + SYNC_LAT) @(posedge Clk);
    #1;
    check("busy_before_rst", Busy, 1'b1);
    @(negedge Clk);
    Reset_n = 1'b0;
    Run     = 1'b0;
    @(posedge Clk);
    #1;
    check("midrst_a", Aval, 8'h00);
    check("midrst_b", Bval, 8'h00);
    check("midrst_x", X, 1'b0);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_done", Done, 1'b0);
    check("midrst_state", dbg_state, IDLE);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    load_b(8'hFD);
    run_mult(8'h07, {1'b1, 16'hFFEB}, 1'b0, 1'b0, 0);

    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
